bcd_counter_multi: RTL

//   Parametrised, cascadable multi-digit synchronous up/down counter; each digit counts modulo DIGIT_MOD (10 = decade/BCD).

---
 rtl/bcd_counter_multi.sv | 115 +++++++++++
 1 files changed

// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi
//   Cascadable multi-digit synchronous up/down counter. Every 4-bit digit
//   counts modulo DIGIT_MOD (10 gives a BCD decade counter). Instances chain
//   by wiring tc of the lower instance to cin of the next-higher one.
//
// Ports
//   clk       rising-edge clock
//   clrbar    asynchronous active-low reset (q, wrap, load_err -> 0)
//   sclr      synchronous clear, highest priority
//   load      synchronous parallel load of d (digits clamped to DIGIT_MOD-1)
//   d         load value, digit i = d[4i+3:4i], digit 0 least significant
//   en        count enable
//   cin       cascade carry/borrow-in (tie 1 when standalone)
//   up_dn     1 = count up, 0 = count down
//   q         count value, same packing as d
//   tc        terminal count / cascade carry-out (combinational)
//   wrap      one-cycle pulse: the previous edge wrapped the full count
//   load_err  one-cycle pulse: the previous load clamped at least one digit
module bcd_counter_multi #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_MOD = 10
) (
    input  logic                  clk,
    input  logic                  clrbar,
    input  logic                  sclr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    input  logic                  en,
    input  logic                  cin,
    input  logic                  up_dn,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    localparam logic [3:0] MAXD = 4'(DIGIT_MOD - 1);

    // Saturate an incoming load digit into the legal digit range.
    function automatic logic [3:0] clamp_digit(input logic [3:0] v);
        return (v > MAXD) ? MAXD : v;
    endfunction

    function automatic logic digit_clamped(input logic [3:0] v);
        return (v > MAXD);
    endfunction

    logic [4*DIGITS-1:0] cnt_p0;
    logic                wrap_p0;
    logic                lerr_p0;

    logic [DIGITS:0]     chain;     // chain[i]=1: digits below i are all at the roll-over value
    logic [4*DIGITS-1:0] cnt_nxt;
    logic [4*DIGITS-1:0] ld_val;
    logic                any_clamp;
    logic                terminal;
    logic                step;

    // Next-state decode: per-digit compare and ripple-free carry/borrow enable
    always_comb begin
        chain     = '0;
        cnt_nxt   = cnt_p0;
        ld_val    = '0;
        any_clamp = 1'b0;
        chain[0]  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            logic [3:0] dig;
            logic [3:0] lim;
            dig = cnt_p0[4*i +: 4];
            lim = up_dn ? MAXD : 4'd0;
            if (chain[i]) begin
                if (up_dn)
                    cnt_nxt[4*i +: 4] = (dig == MAXD) ? 4'd0 : dig + 4'd1;
                else
                    cnt_nxt[4*i +: 4] = (dig == 4'd0) ? MAXD : dig - 4'd1;
            end
            chain[i+1]       = chain[i] & (dig == lim);
            ld_val[4*i +: 4] = clamp_digit(d[4*i +: 4]);
            any_clamp        = any_clamp | digit_clamped(d[4*i +: 4]);
        end
        terminal = chain[DIGITS];
        step     = en & cin;
    end

    assign tc = step & terminal & ~sclr & ~load;

    // Stage p0: count register and status pulses
    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            cnt_p0  <= '0;
            wrap_p0 <= 1'b0;
            lerr_p0 <= 1'b0;
        end else if (sclr) begin
            cnt_p0  <= '0;
            wrap_p0 <= 1'b0;
            lerr_p0 <= 1'b0;
        end else if (load) begin
            cnt_p0  <= ld_val;
            wrap_p0 <= 1'b0;
            lerr_p0 <= any_clamp;
        end else if (step) begin
            cnt_p0  <= cnt_nxt;
            wrap_p0 <= terminal;
            lerr_p0 <= 1'b0;
        end else begin
            wrap_p0 <= 1'b0;
            lerr_p0 <= 1'b0;
        end
    end

    assign q        = cnt_p0;
    assign wrap     = wrap_p0;
    assign load_err = lerr_p0;

endmodule
